sb_bram_slave: RTL and testbench
================================

Name: sb_bram_slave

Overview:
Bus responder (slave) for the shared system bus. It is the counterpart of the JTAG debug-interface master. It serves single and burst reads and writes to an on-chip word-addressed RAM mapped at a fixed window. It drives the responder side of the handshake: read data beats, end-of-transaction, write-side busy stalls and bus error. All of its outputs are OR'd onto the shared bus, so every output must be 0 whenever the block is not actively driving.

Parameters:
BASE_ADDR, 32'h0000_1000, byte address of window start; must be aligned to the window size.
ADDR_BITS, 10, log2 of RAM depth in 32-bit words (1024 words, 4 KiB window).
WAIT_STATES, 2, stall cycles before first read beat or first accepted write beat (0..15).

Ports:
sb_clock_i  in  1  system clock, all logic on rising edge
sb_reset_i  in  1  asynchronous active-high reset
sb_begin_transaction_i  in  1  master start strobe; address/attributes valid this cycle
sb_end_transaction_i  in  1  master end or abort strobe
sb_address_data_i  in  32  byte address on begin; write data on write beats
sb_byte_enables_i  in  4  byte lane enables for write beats
sb_burst_size_i  in  8  beats minus 1 (0 = single word)
sb_read_n_write_i  in  1  1 = read, 0 = write; sampled on begin
sb_data_valid_i  in  1  write beat strobe from master
sb_address_data_o  out  32  read data; 0 when sb_data_valid_o is low
sb_data_valid_o  out  1  read beat strobe
sb_end_transaction_o  out  1  one-cycle end pulse after last read beat
sb_busy_o  out  1  write stall
sb_error_o  out  1  one-cycle bus error pulse

Behaviour:
- Reset (asynchronous): all outputs 0, state IDLE, counters 0. RAM contents are not cleared. Reset mid-burst aborts immediately with no end or error pulse.
- Decode on begin: hit when sb_address_data_i[31:ADDR_BITS+2] == BASE_ADDR[31:ADDR_BITS+2].
- Error conditions, checked on begin: address not in window, address[1:0] != 0, or start word index + burst_size > 2^ADDR_BITS - 1 (burst overruns window).
  - Miss (not in window): ignored silently, stay IDLE.
  - Misalignment or overrun: sb_error_o pulses for 1 cycle at T+1, then IDLE.
- States: IDLE, WAIT, RD, RD_END, WR, ERR.
- IDLE → WAIT on a valid begin. Latch word index, beat count (burst_size+1, 9-bit) and direction; wait counter = WAIT_STATES. If WAIT_STATES = 0, go straight to RD or WR.
- Read timing, begin at cycle T:
  - RAM read issued internally so that beat k appears at T+1+WAIT_STATES+k with sb_data_valid_o = 1, beats back-to-back.
  - sb_end_transaction_o pulses at the cycle after the last beat (RD_END), then IDLE.
  - Word index increments by 1 per beat, no wrap (overrun is rejected up front).
- Write timing:
  - sb_busy_o = 1 from T+1 for WAIT_STATES cycles (WAIT), then 0 in WR.
  - A beat is accepted only when sb_data_valid_i = 1 and sb_busy_o = 0. Accepted beats write sb_address_data_i lanes where sb_byte_enables_i = 1, then the index increments.
  - Beats beyond burst_size+1 are ignored.
  - WR stays until sb_end_transaction_i; the master ends writes, and the slave never pulses end on a write.
- sb_end_transaction_i in any non-IDLE state aborts: next state IDLE, outputs 0 next cycle, no pulses.
- sb_begin_transaction_i while not IDLE is ignored.
- sb_begin_transaction_i and sb_end_transaction_i together in IDLE: begin wins.
- A beat coincident with end in WR is still written.
- sb_data_valid_i in IDLE/WAIT/ERR is ignored.

Decomposition:
- Package sb_bus_pkg: state enum, burst-size width (8), data width (32), byte-enable width (4).
- Sub-module sb_bram_slave_mem: single-port synchronous RAM with 1-cycle read latency and 4 byte write enables, depth 2^ADDR_BITS.
- The controller FSM stays in sb_bram_slave.

Test Plan:
- Single write then read: write 32'hDEAD_BEEF to 0x1000 with BE=4'hF, burst 0, WAIT_STATES=2 → busy high exactly 2 cycles, beat accepted. Then read 0x1000 → valid at T+3 with 32'hDEAD_BEEF; end pulse at T+4; all outputs 0 after.
- Burst read: preload 0x1010..0x101C with 1,2,3,4; burst_size=3 → 4 consecutive valid beats 1,2,3,4, then one end pulse.
- Byte enables: write 32'h1122_3344 BE=4'hF, then 32'hAABB_CCDD BE=4'b0101 to 0x1004 → readback 32'h11BB_33DD.
- Errors: read 0x1002 → single sb_error_o pulse at T+1, no valid/end. Burst_size=3 at 0x1FF8 → error. Address 0x2000 → no outputs at all.
- Abort: 8-beat read with sb_end_transaction_i at beat 3 → valid drops next cycle, no end pulse. A new begin 2 cycles later is served normally.
- Reset mid-write: assert sb_reset_i during WR → outputs 0 immediately. Earlier accepted beats remain readable after reset.

Source files
------------

// File: rtl/sb_bus_pkg.sv
// Shared system-bus definitions: controller states and bus field widths.
// Imported by the bus interface, the RAM responder and its storage.
// Pure declarations, no logic.
package sb_bus_pkg;

  localparam int SB_DATA_W  = 32;
  localparam int SB_BURST_W = 8;
  localparam int SB_BE_W    = 4;
  // beat counter holds burst_size + 1, so one bit wider than the burst field
  localparam int SB_CNT_W   = SB_BURST_W + 1;
  localparam int SB_WAIT_W  = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_RD,
    S_RD_END,
    S_WR,
    S_ERR
  } sb_state_e;

endpackage

// File: rtl/sb_bram_slave_if.sv
// Shared system-bus signal bundle between one master and one responder.
// Signal names carry the responder's point of view (_i into it, _o out of it).
// No logic; the master modport simply drives the _i side.
interface sb_bram_slave_if;
  import sb_bus_pkg::*;

  logic                  sb_begin_transaction_i;
  logic                  sb_end_transaction_i;
  logic [SB_DATA_W-1:0]  sb_address_data_i;
  logic [SB_BE_W-1:0]    sb_byte_enables_i;
  logic [SB_BURST_W-1:0] sb_burst_size_i;
  logic                  sb_read_n_write_i;
  logic                  sb_data_valid_i;
  logic [SB_DATA_W-1:0]  sb_address_data_o;
  logic                  sb_data_valid_o;
  logic                  sb_end_transaction_o;
  logic                  sb_busy_o;
  logic                  sb_error_o;

  modport master (
    output sb_begin_transaction_i, sb_end_transaction_i, sb_address_data_i,
           sb_byte_enables_i, sb_burst_size_i, sb_read_n_write_i, sb_data_valid_i,
    input  sb_address_data_o, sb_data_valid_o, sb_end_transaction_o,
           sb_busy_o, sb_error_o
  );

  modport slave (
    input  sb_begin_transaction_i, sb_end_transaction_i, sb_address_data_i,
           sb_byte_enables_i, sb_burst_size_i, sb_read_n_write_i, sb_data_valid_i,
    output sb_address_data_o, sb_data_valid_o, sb_end_transaction_o,
           sb_busy_o, sb_error_o
  );

endinterface

// File: rtl/sb_bram_slave_mem.sv
// Single-port word RAM with per-byte write enables; contents survive reset.
// Latency: read data registered, valid one cycle after the address.
// Backpressure: none, accepts an access every cycle.
module sb_bram_slave_mem
  import sb_bus_pkg::*;
#(
  parameter int ADDR_BITS = 10
) (
  input  logic                 clk_i,
  input  logic [ADDR_BITS-1:0] addr_i,
  input  logic [SB_DATA_W-1:0] wdata_i,
  input  logic [SB_BE_W-1:0]   be_i,
  input  logic                 we_i,
  output logic [SB_DATA_W-1:0] rdata_o
);

  logic [SB_DATA_W-1:0] mem_q [2**ADDR_BITS];
  logic [SB_DATA_W-1:0] rdata_q;

  // byte-lane write and read-before-write registered read on the same port
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < SB_BE_W; b++) begin
        if (be_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sb_bram_slave.sv
// System-bus responder serving single/burst reads and writes to an on-chip RAM window.
// Latency: first read beat / first accepted write beat WAIT_STATES+1 cycles after begin.
// Backpressure: busy stalls write beats during the wait phase; outputs are 0 when idle.
module sb_bram_slave
  import sb_bus_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
  parameter int          ADDR_BITS   = 10,
  parameter int          WAIT_STATES = 2
) (
  input  logic             sb_clock_i,
  input  logic             sb_reset_i,
  sb_bram_slave_if.slave   bus
);

  localparam logic [31:0]          LAST_IDX  = 32'((1 << ADDR_BITS) - 1);
  localparam logic [SB_WAIT_W-1:0] WAIT_INIT = SB_WAIT_W'(WAIT_STATES);
  localparam logic [ADDR_BITS-1:0] IDX_ONE   = ADDR_BITS'(1);

  sb_state_e              state_q, state_d;
  logic [ADDR_BITS-1:0]   idx_q, idx_d;
  logic [SB_CNT_W-1:0]    cnt_q, cnt_d;
  logic [SB_WAIT_W-1:0]   wait_q, wait_d;
  logic                   rd_q, rd_d;

  logic [ADDR_BITS-1:0]   mem_addr;
  logic                   mem_we;
  logic [SB_DATA_W-1:0]   mem_rdata;

  // begin-time decode of the incoming address/burst
  logic [ADDR_BITS-1:0]   in_idx;
  logic                   in_hit, in_misaligned, in_overrun;
  logic [31:0]            in_last;

  assign in_idx        = bus.sb_address_data_i[ADDR_BITS+1:2];
  assign in_hit        = bus.sb_address_data_i[31:ADDR_BITS+2] == BASE_ADDR[31:ADDR_BITS+2];
  assign in_misaligned = |bus.sb_address_data_i[1:0];
  assign in_last       = 32'(in_idx) + 32'(bus.sb_burst_size_i);
  assign in_overrun    = in_last > LAST_IDX;

  // controller state, indices and counters
  always_ff @(posedge sb_clock_i or posedge sb_reset_i) begin
    if (sb_reset_i) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      wait_q  <= '0;
      rd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      wait_q  <= wait_d;
      rd_q    <= rd_d;
    end
  end

  // next state and RAM port control; the RAM address always points at the
  // word that must be on the bus in the following cycle
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    wait_d   = wait_q;
    rd_d     = rd_q;
    mem_addr = idx_q;
    mem_we   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        mem_addr = in_idx;
        if (bus.sb_begin_transaction_i && in_hit) begin
          if (in_misaligned || in_overrun) begin
            state_d = S_ERR;
          end else begin
            idx_d  = in_idx;
            cnt_d  = {1'b0, bus.sb_burst_size_i} + SB_CNT_W'(1);
            rd_d   = bus.sb_read_n_write_i;
            wait_d = WAIT_INIT;
            if (WAIT_STATES == 0) state_d = bus.sb_read_n_write_i ? S_RD : S_WR;
            else                  state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (bus.sb_end_transaction_i)  state_d = S_IDLE;
        else if (wait_q == SB_WAIT_W'(1)) state_d = rd_q ? S_RD : S_WR;
        else                           wait_d  = wait_q - SB_WAIT_W'(1);
      end
      S_RD: begin
        mem_addr = idx_q + IDX_ONE;
        idx_d    = idx_q + IDX_ONE;
        cnt_d    = cnt_q - SB_CNT_W'(1);
        if (bus.sb_end_transaction_i)   state_d = S_IDLE;
        else if (cnt_q == SB_CNT_W'(1)) state_d = S_RD_END;
      end
      S_RD_END: state_d = S_IDLE;
      S_WR: begin
        if (bus.sb_data_valid_i && cnt_q != '0) begin
          mem_we = 1'b1;
          idx_d  = idx_q + IDX_ONE;
          cnt_d  = cnt_q - SB_CNT_W'(1);
        end
        if (bus.sb_end_transaction_i) state_d = S_IDLE;
      end
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  sb_bram_slave_mem #(.ADDR_BITS(ADDR_BITS)) u_mem (
    .clk_i   (sb_clock_i),
    .addr_i  (mem_addr),
    .wdata_i (bus.sb_address_data_i),
    .be_i    (bus.sb_byte_enables_i),
    .we_i    (mem_we),
    .rdata_o (mem_rdata)
  );

  // outputs decode straight from state so reset zeroes them at once
  assign bus.sb_data_valid_o      = state_q == S_RD;
  assign bus.sb_address_data_o    = bus.sb_data_valid_o ? mem_rdata : '0;
  assign bus.sb_end_transaction_o = state_q == S_RD_END;
  assign bus.sb_busy_o            = (state_q == S_WAIT) && !rd_q;
  assign bus.sb_error_o           = state_q == S_ERR;

endmodule

// File: tb/tb_sb_bram_slave.sv
// Directed bench for sb_bram_slave with WAIT_STATES = 2 and a 4 KiB window at 0x1000.
module tb_sb_bram_slave;
  localparam int W = 2;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [31:0] wdat [8];
  logic [3:0]  wbe  [8];
  logic [31:0] rexp [8];
  int          busy_cycles;

  sb_bram_slave_if bus();

  sb_bram_slave #(
    .BASE_ADDR   (32'h0000_1000),
    .ADDR_BITS   (10),
    .WAIT_STATES (W)
  ) dut (
    .sb_clock_i (clk),
    .sb_reset_i (rst),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // advance one cycle; inputs change and outputs are sampled 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ctl();
    return {28'd0, bus.sb_data_valid_o, bus.sb_end_transaction_o, bus.sb_busy_o, bus.sb_error_o};
  endfunction

  task automatic chk_quiet(input string tag);
    chk({tag, "_ctl"}, ctl(), 32'd0);
    chk({tag, "_dat"}, bus.sb_address_data_o, 32'd0);
  endtask

  task automatic start(input logic [31:0] addr, input logic [7:0] burst, input logic rnw);
    bus.sb_begin_transaction_i = 1'b1;
    bus.sb_address_data_i      = addr;
    bus.sb_burst_size_i        = burst;
    bus.sb_read_n_write_i      = rnw;
    tick();
    bus.sb_begin_transaction_i = 1'b0;
    bus.sb_address_data_i      = '0;
  endtask

  // drives nbeats write beats (may exceed burst+1), then ends the transaction
  task automatic do_write(input logic [31:0] addr, input logic [7:0] burst, input int nbeats);
    int sent = 0;
    busy_cycles = 0;
    start(addr, burst, 1'b0);
    for (int g = 0; g < 40 && sent < nbeats; g++) begin
      if (bus.sb_busy_o) begin
        busy_cycles++;
        bus.sb_data_valid_i = 1'b0;
      end else begin
        bus.sb_data_valid_i   = 1'b1;
        bus.sb_address_data_i = wdat[sent];
        bus.sb_byte_enables_i = wbe[sent];
        sent++;
      end
      tick();
    end
    chk("wr_beats_sent", sent, nbeats);
    bus.sb_data_valid_i      = 1'b0;
    bus.sb_address_data_i    = '0;
    bus.sb_end_transaction_i = 1'b1;
    tick();
    bus.sb_end_transaction_i = 1'b0;
  endtask

  // full read with exact-cycle checks of every beat and the end pulse
  task automatic do_read(input string tag, input logic [31:0] addr, input logic [7:0] burst);
    start(addr, burst, 1'b1);
    for (int c = 0; c < W; c++) begin
      chk({tag, "_wait_vld"}, 32'(bus.sb_data_valid_o), 32'd0);
      tick();
    end
    for (int k = 0; k <= int'(burst); k++) begin
      chk({tag, "_beat_vld"}, 32'(bus.sb_data_valid_o), 32'd1);
      chk({tag, "_beat_dat"}, bus.sb_address_data_o, rexp[k]);
      chk({tag, "_beat_end"}, 32'(bus.sb_end_transaction_o), 32'd0);
      tick();
    end
    chk({tag, "_end_ctl"}, ctl(), 32'h4);
    tick();
    chk_quiet({tag, "_after"});
  endtask

  initial begin
    rst = 1'b1;
    bus.sb_begin_transaction_i = 1'b0;
    bus.sb_end_transaction_i   = 1'b0;
    bus.sb_address_data_i      = '0;
    bus.sb_byte_enables_i      = '0;
    bus.sb_burst_size_i        = '0;
    bus.sb_read_n_write_i      = 1'b0;
    bus.sb_data_valid_i        = 1'b0;
    tick();
    tick();
    chk_quiet("reset");
    rst = 1'b0;
    tick();

    // single write then read
    wdat[0] = 32'hDEAD_BEEF; wbe[0] = 4'hF;
    do_write(32'h1000, 8'd0, 1);
    chk("wr_busy_cycles", busy_cycles, W);
    rexp[0] = 32'hDEAD_BEEF;
    do_read("rd_single", 32'h1000, 8'd0);

    // burst write 1..4 then burst read
    for (int i = 0; i < 4; i++) begin
      wdat[i] = 32'(i + 1); wbe[i] = 4'hF; rexp[i] = 32'(i + 1);
    end
    do_write(32'h1010, 8'd3, 4);
    do_read("rd_burst", 32'h1010, 8'd3);

    // byte enables
    wdat[0] = 32'h1122_3344; wbe[0] = 4'hF;
    do_write(32'h1004, 8'd0, 1);
    wdat[0] = 32'hAABB_CCDD; wbe[0] = 4'b0101;
    do_write(32'h1004, 8'd0, 1);
    rexp[0] = 32'h11BB_33DD;
    do_read("rd_be", 32'h1004, 8'd0);

    // beats past burst+1 are dropped
    wdat[0] = 32'h7777_7777; wbe[0] = 4'hF;
    do_write(32'h100C, 8'd0, 1);
    wdat[0] = 32'h5555_5555; wdat[1] = 32'h6666_6666; wbe[1] = 4'hF;
    do_write(32'h1008, 8'd0, 2);
    rexp[0] = 32'h5555_5555; rexp[1] = 32'h7777_7777;
    do_read("rd_extra", 32'h1008, 8'd1);

    // misaligned read: one error pulse, nothing else
    start(32'h1002, 8'd0, 1'b1);
    chk("mis_ctl_t1", ctl(), 32'h1);
    chk("mis_dat_t1", bus.sb_address_data_o, 32'd0);
    for (int c = 0; c < 4; c++) begin
      tick();
      chk_quiet("mis_after");
    end

    // burst overrunning the window top
    start(32'h1FF8, 8'd3, 1'b1);
    chk("ovr_ctl_t1", ctl(), 32'h1);
    tick();
    chk_quiet("ovr_after");

    // window miss: silent
    start(32'h2000, 8'd0, 1'b1);
    for (int c = 0; c < 4; c++) begin
      chk_quiet("miss");
      tick();
    end

    // burst ending exactly on the last word is accepted; abort it once it streams
    start(32'h1FF0, 8'd3, 1'b1);
    chk("edge_ctl_t1", ctl(), 32'h0);
    tick();
    tick();
    chk("edge_vld_t3", 32'(bus.sb_data_valid_o), 32'd1);
    bus.sb_end_transaction_i = 1'b1;
    tick();
    bus.sb_end_transaction_i = 1'b0;
    chk_quiet("edge_abort");

    // 8-beat read aborted on its third beat, then a normal read 2 cycles later
    start(32'h1010, 8'd7, 1'b1);
    tick();
    tick();
    chk("ab_b0", bus.sb_address_data_o, 32'd1);
    tick();
    chk("ab_b1", bus.sb_address_data_o, 32'd2);
    tick();
    chk("ab_b2", bus.sb_address_data_o, 32'd3);
    bus.sb_end_transaction_i = 1'b1;
    tick();
    bus.sb_end_transaction_i = 1'b0;
    chk_quiet("ab_next");
    tick();
    chk_quiet("ab_next2");
    rexp[0] = 32'hDEAD_BEEF;
    do_read("ab_resume", 32'h1000, 8'd0);

    // reset while the write stall is active drops busy at once
    start(32'h1040, 8'd0, 1'b0);
    chk("rstw_busy", 32'(bus.sb_busy_o), 32'd1);
    rst = 1'b1;
    #1;
    chk_quiet("rstw_async");
    rst = 1'b0;
    tick();

    // reset in the middle of a burst write; accepted beats survive
    start(32'h1020, 8'd3, 1'b0);
    tick();
    tick();
    chk("rstm_busy_wr", 32'(bus.sb_busy_o), 32'd0);
    bus.sb_data_valid_i = 1'b1; bus.sb_byte_enables_i = 4'hF;
    bus.sb_address_data_i = 32'hA5A5_0001;
    tick();
    bus.sb_address_data_i = 32'hA5A5_0002;
    tick();
    bus.sb_data_valid_i = 1'b0; bus.sb_address_data_i = '0;
    rst = 1'b1;
    #1;
    chk_quiet("rstm_async");
    tick();
    rst = 1'b0;
    tick();
    chk_quiet("rstm_idle");
    rexp[0] = 32'hA5A5_0001; rexp[1] = 32'hA5A5_0002;
    do_read("rstm_read", 32'h1020, 8'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
